seg_display_driver: RTL and testbench

- Downstream consumer of the stopwatch counting stage. Takes binary minutes/seconds (0-59 each) and drives a 4-digit, common-anode, multiplexed 7-segment display as MM.SS.
- Converts each value to two BCD digits, scans the digits in time-multiplex, and lights the decimal point as the MM/SS separator.
- Blinks the digit pair under adjustment while adjust mode is active.
- Runs on the system clock, not the stopwatch tick.

---
 rtl/seg_display_driver.sv | 178 +++++++++++++++++
 tb/tb_seg_display_driver.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/seg_display_driver.sv
// seg_display_driver
//   Drives a 4-digit, common-anode, multiplexed 7-segment display as MM.SS
//   from binary minutes/seconds. Each field becomes two BCD digits. The digits
//   are scanned one at a time, and the decimal point after the minutes ones
//   digit acts as the separator. While adjust is active, the digit pair under
//   adjustment blinks.
//
// Parameters
//   REFRESH_DIV : clk cycles each digit stays lit (>= 2)
//   BLINK_DIV   : clk cycles per blink half-period (>= 2)
//
// Ports
//   clk     : system clock, rising edge
//   reset   : asynchronous, active-low reset (display dark)
//   minutes : binary minutes 0..59 (60..63 shown as dashes)
//   seconds : binary seconds 0..59 (60..63 shown as dashes)
//   adjust  : adjust mode active, enables blinking
//   select  : blink target, 0 = minutes pair, 1 = seconds pair
//   an      : digit enables, active-low, an[3] = minutes tens .. an[0] = seconds ones
//   seg     : segment cathodes, active-low, {g,f,e,d,c,b,a}
//   dp      : decimal point, active-low
module seg_display_driver #(
  parameter int unsigned REFRESH_DIV = 100000,
  parameter int unsigned BLINK_DIV   = 25000000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] minutes,
  input  logic [5:0] seconds,
  input  logic       adjust,
  input  logic       select,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  typedef enum logic {
    PH_ON  = 1'b0,
    PH_OFF = 1'b1
  } phase_t;

  logic [RW-1:0] r_refresh_cnt;
  logic [1:0]    r_digit;
  logic [BW-1:0] r_blink_cnt;
  phase_t        r_phase;
  logic [5:0]    r_min_cap;
  logic [5:0]    r_sec_cap;

  logic          w_refresh_wrap;
  logic          w_blink_wrap;
  logic [7:0]    w_min_bcd;
  logic [7:0]    w_sec_bcd;
  logic          w_min_dash;
  logic          w_sec_dash;
  logic [3:0]    w_digit_val;
  logic          w_digit_dash;
  logic [6:0]    w_digit_seg;
  logic          w_blank;

  // Binary 0..59 to {tens, ones} by range compare and subtract.
  // Only the low nibble of the remainder is needed: it is below 10, so the
  // subtraction modulo 16 (of v[3:0] and the tens offset mod 16) is exact.
  function automatic logic [7:0] f_bcd(input logic [5:0] v);
    logic [3:0] tens;
    logic [3:0] ones;
    if (v >= 6'd50) begin
      tens = 4'd5;
      ones = v[3:0] - 4'd2;   // 50 mod 16
    end else if (v >= 6'd40) begin
      tens = 4'd4;
      ones = v[3:0] - 4'd8;   // 40 mod 16
    end else if (v >= 6'd30) begin
      tens = 4'd3;
      ones = v[3:0] - 4'd14;  // 30 mod 16
    end else if (v >= 6'd20) begin
      tens = 4'd2;
      ones = v[3:0] - 4'd4;   // 20 mod 16
    end else if (v >= 6'd10) begin
      tens = 4'd1;
      ones = v[3:0] - 4'd10;
    end else begin
      tens = 4'd0;
      ones = v[3:0];
    end
    return {tens, ones};
  endfunction

  function automatic logic [6:0] f_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h40;
      4'd1:    s = 7'h79;
      4'd2:    s = 7'h24;
      4'd3:    s = 7'h30;
      4'd4:    s = 7'h19;
      4'd5:    s = 7'h12;
      4'd6:    s = 7'h02;
      4'd7:    s = 7'h78;
      4'd8:    s = 7'h00;
      4'd9:    s = 7'h10;
      default: s = 7'h7F;
    endcase
    return s;
  endfunction

  always_comb begin
    w_refresh_wrap = (r_refresh_cnt == RW'(REFRESH_DIV - 1));
    w_blink_wrap   = (r_blink_cnt == BW'(BLINK_DIV - 1));

    w_min_bcd  = f_bcd(r_min_cap);
    w_sec_bcd  = f_bcd(r_sec_cap);
    w_min_dash = (r_min_cap > 6'd59);
    w_sec_dash = (r_sec_cap > 6'd59);

    w_digit_val  = 4'd0;
    w_digit_dash = 1'b0;
    case (r_digit)
      2'd0: begin w_digit_val = w_sec_bcd[3:0]; w_digit_dash = w_sec_dash; end
      2'd1: begin w_digit_val = w_sec_bcd[7:4]; w_digit_dash = w_sec_dash; end
      2'd2: begin w_digit_val = w_min_bcd[3:0]; w_digit_dash = w_min_dash; end
      default: begin w_digit_val = w_min_bcd[7:4]; w_digit_dash = w_min_dash; end
    endcase
    w_digit_seg = w_digit_dash ? 7'h3F : f_seg(w_digit_val);

    // r_digit[1] is 1 for the minutes pair; the selected pair is blanked in the off phase.
    w_blank = (r_phase == PH_OFF) && (r_digit[1] != select);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_refresh_cnt <= '0;
      r_digit       <= '0;
      r_blink_cnt   <= '0;
      r_phase       <= PH_ON;
      r_min_cap     <= '0;
      r_sec_cap     <= '0;
      an            <= '1;
      seg           <= '1;
      dp            <= 1'b1;
    end else begin
      if (w_refresh_wrap) begin
        r_refresh_cnt <= '0;
        r_digit       <= r_digit + 2'd1;
        // Sample a whole frame at once so a frame never mixes two input values.
        if (r_digit == 2'd3) begin
          r_min_cap <= minutes;
          r_sec_cap <= seconds;
        end
      end else begin
        r_refresh_cnt <= r_refresh_cnt + 1'b1;
      end

      if (!adjust) begin
        r_blink_cnt <= '0;
        r_phase     <= PH_ON;
      end else if (w_blink_wrap) begin
        r_blink_cnt <= '0;
        r_phase     <= (r_phase == PH_ON) ? PH_OFF : PH_ON;
      end else begin
        r_blink_cnt <= r_blink_cnt + 1'b1;
      end

      if (w_blank) begin
        an  <= '1;
        seg <= '1;
        dp  <= 1'b1;
      end else begin
        an  <= ~(4'b0001 << r_digit);
        seg <= w_digit_seg;
        dp  <= (r_digit != 2'd2);
      end
    end
  end

endmodule

// File: tb/tb_seg_display_driver.sv
module tb_seg_display_driver;

  localparam int unsigned RDIV = 4;
  localparam int unsigned BDIV = 8;

  logic       clk = 1'b0;
  logic       clk_en;
  logic       reset;
  logic [5:0] minutes;
  logic [5:0] seconds;
  logic       adjust;
  logic       select;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp;

  typedef struct {
    int         cyc;   // -1: compare immediately on ev_chk
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    string      name;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   cycle  = 0;
  int   base   = 0;
  event ev_chk;

  seg_display_driver #(
    .REFRESH_DIV(RDIV),
    .BLINK_DIV  (BDIV)
  ) u_dut (
    .clk    (clk),
    .reset  (reset),
    .minutes(minutes),
    .seconds(seconds),
    .adjust (adjust),
    .select (select),
    .an     (an),
    .seg    (seg),
    .dp     (dp)
  );

  always #5 if (clk_en) clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic push(input int cyc, input logic [3:0] a, input logic [6:0] s,
                      input logic d, input string n);
    exp_t e;
    e.cyc  = cyc;
    e.an   = a;
    e.seg  = s;
    e.dp   = d;
    e.name = n;
    q.push_back(e);
  endtask

  task automatic expect_rng(input int k0, input int k1, input logic [3:0] a,
                            input logic [6:0] s, input logic d, input string n);
    for (int k = k0; k <= k1; k++)
      push(base + k, a, s, d, $sformatf("%s@E%0d", n, k));
  endtask

  task automatic frame(input int k0, input logic [6:0] s0, input logic [6:0] s1,
                       input logic [6:0] s2, input logic [6:0] s3, input string n);
    expect_rng(k0,      k0 + 3,  4'b1110, s0, 1'b1, {n, "_d0"});
    expect_rng(k0 + 4,  k0 + 7,  4'b1101, s1, 1'b1, {n, "_d1"});
    expect_rng(k0 + 8,  k0 + 11, 4'b1011, s2, 1'b0, {n, "_d2"});
    expect_rng(k0 + 12, k0 + 15, 4'b0111, s3, 1'b1, {n, "_d3"});
  endtask

  task automatic at_edge(input int k);
    while (cycle < base + k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compares whatever expectation is due for the current cycle.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or ev_chk);
      while (q.size() > 0 && (q[0].cyc < 0 || q[0].cyc <= cycle)) begin
        e = q.pop_front();
        checks++;
        if (e.cyc >= 0 && e.cyc < cycle) begin
          errors++;
          $display("FAIL %s: slot missed at cycle %0d, required an=%b seg=%h dp=%b",
                   e.name, cycle, e.an, e.seg, e.dp);
        end else if ({an, seg, dp} !== {e.an, e.seg, e.dp}) begin
          errors++;
          $display("FAIL %s: got an=%b seg=%h dp=%b, required an=%b seg=%h dp=%b",
                   e.name, an, seg, dp, e.an, e.seg, e.dp);
        end
      end
    end
  end

  initial begin : stim
    reset   = 1'b1;
    adjust  = 1'b0;
    select  = 1'b0;
    minutes = 6'd12;
    seconds = 6'd34;
    clk_en  = 1'b1;
    repeat (3) @(posedge clk);

    // Reset with the clock stopped: display must go dark with no edge.
    @(negedge clk);
    clk_en = 1'b0;
    #2;
    reset = 1'b0;
    #30;
    push(-1, 4'b1111, 7'h7F, 1'b1, "reset_async_dark");
    ->ev_chk;
    #1;
    reset = 1'b1;
    #2;
    base = cycle;

    frame(1,  7'h40, 7'h40, 7'h40, 7'h40, "f0_zero");
    frame(17, 7'h19, 7'h30, 7'h24, 7'h79, "f1_1234");
    frame(33, 7'h19, 7'h30, 7'h24, 7'h79, "f2_tear");
    frame(49, 7'h02, 7'h12, 7'h24, 7'h79, "f3_1256");
    frame(65, 7'h78, 7'h40, 7'h3F, 7'h3F, "f4_range");
    frame(81, 7'h10, 7'h12, 7'h10, 7'h12, "f5_5959");
    expect_rng(97,  100, 4'b1111, 7'h7F, 1'b1, "f6_sel1_blank_d0");
    expect_rng(101, 104, 4'b1101, 7'h12, 1'b1, "f6_sel1_on_d1");
    expect_rng(105, 108, 4'b1011, 7'h10, 1'b0, "f6_d2");
    expect_rng(109, 112, 4'b0111, 7'h12, 1'b1, "f6_d3_unselected");
    expect_rng(113, 116, 4'b1110, 7'h10, 1'b1, "f7_sel0_d0");
    expect_rng(117, 120, 4'b1101, 7'h12, 1'b1, "f7_d1");
    expect_rng(121, 124, 4'b1011, 7'h10, 1'b0, "f7_d2");
    expect_rng(125, 127, 4'b1111, 7'h7F, 1'b1, "f7_sel0_blank_d3");
    expect_rng(128, 128, 4'b0111, 7'h12, 1'b1, "f7_adj_off_reappear");
    frame(129, 7'h10, 7'h12, 7'h10, 7'h12, "f8_noadj");
    expect_rng(145, 148, 4'b1110, 7'h10, 1'b1, "f9_d0");
    expect_rng(149, 152, 4'b1101, 7'h12, 1'b1, "f9_d1");
    expect_rng(153, 154, 4'b1111, 7'h7F, 1'b1, "f9_blank_d2");

    clk_en = 1'b1;

    at_edge(37);  seconds = 6'd56;
    at_edge(49);  minutes = 6'd60; seconds = 6'd7;
    at_edge(65);  minutes = 6'd59; seconds = 6'd59;
    at_edge(84);  adjust  = 1'b1;  select  = 1'b1;
    at_edge(112); select  = 1'b0;
    at_edge(126); adjust  = 1'b0;
    at_edge(144); adjust  = 1'b1;

    // Reset in the middle of digit 2 during a blink-off phase.
    at_edge(154);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    push(-1, 4'b1111, 7'h7F, 1'b1, "reset_mid_blink_dark");
    ->ev_chk;
    push(cycle + 1, 4'b1111, 7'h7F, 1'b1, "reset_held_dark");
    @(negedge clk);
    @(negedge clk);
    #2;
    reset = 1'b1;
    base  = cycle;

    expect_rng(1,  4,  4'b1110, 7'h40, 1'b1, "rst2_restart_d0");
    expect_rng(5,  8,  4'b1101, 7'h40, 1'b1, "rst2_d1");
    expect_rng(9,  16, 4'b1111, 7'h7F, 1'b1, "rst2_first_off_phase");
    expect_rng(17, 20, 4'b1110, 7'h10, 1'b1, "rst2_f1_d0");
    expect_rng(21, 24, 4'b1101, 7'h12, 1'b1, "rst2_f1_d1");

    for (int i = 0; i < 100 && q.size() > 0; i++) @(posedge clk);
    @(negedge clk);
    #1;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expected outputs never observed, required 0", q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
